// File: rtl/id_wb_scoreboard_pkg.sv
// id_wb_scoreboard_pkg: shared widths, types and helpers for the issue/writeback scoreboard
// Provides the REG_NUM / COMMON_WIDTH / WB_AGE_MAX defines plus types used by all files.
`ifndef ID_WB_DEFINE_H
`define ID_WB_DEFINE_H
`define REG_NUM 5
`define COMMON_WIDTH 32
`define WB_AGE_MAX 3
`endif

package id_wb_scoreboard_pkg;
    localparam int RW = `REG_NUM;
    localparam int DW = `COMMON_WIDTH;
    localparam int AGE_MAX = `WB_AGE_MAX;
    localparam int NREG = 1 << RW;

    typedef logic [RW-1:0] reg_idx_t;
    typedef logic [DW-1:0] data_t;

    typedef enum logic [1:0] {SRC_NONE, SRC_ALU, SRC_BUF, SRC_LSU} wb_src_t;

    // x0 maps to an all-zero mask so it can never be marked busy or cleared
    function automatic logic [NREG-1:0] onehot(reg_idx_t r);
        onehot = '0;
        onehot[r] = (r != '0);
    endfunction
endpackage

// File: rtl/id_wb_scoreboard_if.sv
// id_wb_scoreboard_if: issue, ALU/LSU writeback and register-file write bundle
// master = decode/execute side driving requests; slave = scoreboard.
interface id_wb_scoreboard_if;
    import id_wb_scoreboard_pkg::*;
    logic     iss_valid;
    reg_idx_t iss_rs1;
    reg_idx_t iss_rs2;
    reg_idx_t iss_rd;
    logic     iss_rd_en;
    logic     iss_stall;
    logic     alu_wb_valid;
    logic     alu_wb_ready;
    reg_idx_t alu_wb_rd;
    data_t    alu_wb_data;
    logic     lsu_wb_valid;
    logic     lsu_wb_ready;
    reg_idx_t lsu_wb_rd;
    data_t    lsu_wb_data;
    reg_idx_t rf_rd;
    data_t    rf_data;

    modport master (
        output iss_valid, iss_rs1, iss_rs2, iss_rd, iss_rd_en,
        output alu_wb_valid, alu_wb_rd, alu_wb_data,
        output lsu_wb_valid, lsu_wb_rd, lsu_wb_data,
        input  iss_stall, alu_wb_ready, lsu_wb_ready, rf_rd, rf_data
    );

    modport slave (
        input  iss_valid, iss_rs1, iss_rs2, iss_rd, iss_rd_en,
        input  alu_wb_valid, alu_wb_rd, alu_wb_data,
        input  lsu_wb_valid, lsu_wb_rd, lsu_wb_data,
        output iss_stall, alu_wb_ready, lsu_wb_ready, rf_rd, rf_data
    );
endinterface

// File: rtl/id_wb_arbiter.sv
// id_wb_arbiter: single-port writeback arbiter with a one-entry aging LSU holding buffer
// Ports: clk, rst; alu_valid/alu_ready/alu_rd/alu_data and lsu_* writeback handshakes;
// rf_rd/rf_data registered register-file write port (rf_rd=0 means no write).
module id_wb_arbiter
    import id_wb_scoreboard_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     alu_valid,
    input  reg_idx_t alu_rd,
    input  data_t    alu_data,
    output logic     alu_ready,
    input  logic     lsu_valid,
    input  reg_idx_t lsu_rd,
    input  data_t    lsu_data,
    output logic     lsu_ready,
    output reg_idx_t rf_rd,
    output data_t    rf_data
);
    logic     buf_valid;
    reg_idx_t buf_rd;
    data_t    buf_data;
    logic [1:0] age;
    logic     alu_v, lsu_v, drain_old, buf_drain, lsu_acc, lsu_direct, lsu_load;
    wb_src_t  src;

    // rd=0 results are still handshaken but never compete for the write slot
    always_comb begin
        alu_v      = alu_valid && (alu_rd != '0);
        lsu_v      = lsu_valid && (lsu_rd != '0);
        drain_old  = buf_valid && (age == 2'(AGE_MAX));
        buf_drain  = buf_valid && (drain_old || !alu_v);
        alu_ready  = !rst && !drain_old;
        lsu_ready  = !rst && (!buf_valid || buf_drain);
        lsu_acc    = lsu_v && lsu_ready;
        lsu_direct = lsu_acc && !buf_valid && !alu_v;
        lsu_load   = lsu_acc && !lsu_direct;
        src        = buf_drain ? SRC_BUF : alu_v ? SRC_ALU : lsu_direct ? SRC_LSU : SRC_NONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid <= 1'b0;
            buf_rd    <= '0;
            buf_data  <= '0;
            age       <= '0;
            rf_rd     <= '0;
            rf_data   <= '0;
        end else begin
            buf_valid <= lsu_load || (buf_valid && !buf_drain);
            if (lsu_load) begin
                buf_rd   <= lsu_rd;
                buf_data <= lsu_data;
            end
            age   <= (lsu_load || buf_drain || !buf_valid) ? '0 :
                     (age != 2'(AGE_MAX)) ? age + 2'd1 : age;
            rf_rd <= src == SRC_BUF ? buf_rd : src == SRC_ALU ? alu_rd :
                     src == SRC_LSU ? lsu_rd : '0;
            if (src != SRC_NONE)
                rf_data <= src == SRC_BUF ? buf_data : src == SRC_ALU ? alu_data : lsu_data;
        end
    end
endmodule

// File: rtl/id_wb_scoreboard.sv
// id_wb_scoreboard: register busy scoreboard with issue stall and arbitrated writeback
// Ports: clk, rst; bus (id_wb_scoreboard_if.slave) carrying issue, ALU/LSU writeback and rf write port.
module id_wb_scoreboard
    import id_wb_scoreboard_pkg::*;
(
    input logic               clk,
    input logic               rst,
    id_wb_scoreboard_if.slave bus
);
    logic [NREG-1:0] busy, set_v, clr_v;
    logic issue;

    // Busy clears only once the write has been presented on rf_rd, so there is no bypass
    always_comb begin
        bus.iss_stall = rst || (bus.iss_valid && (busy[bus.iss_rs1] || busy[bus.iss_rs2] ||
                        (bus.iss_rd_en && busy[bus.iss_rd])));
        issue         = bus.iss_valid && !bus.iss_stall;
        set_v         = (issue && bus.iss_rd_en) ? onehot(bus.iss_rd) : '0;
        clr_v         = onehot(bus.rf_rd);
    end

    always_ff @(posedge clk) begin
        if (rst)
            busy <= '0;
        else
            busy <= (busy & ~clr_v) | set_v;
    end

    id_wb_arbiter u_arb (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (bus.alu_wb_valid),
        .alu_rd    (bus.alu_wb_rd),
        .alu_data  (bus.alu_wb_data),
        .alu_ready (bus.alu_wb_ready),
        .lsu_valid (bus.lsu_wb_valid),
        .lsu_rd    (bus.lsu_wb_rd),
        .lsu_data  (bus.lsu_wb_data),
        .lsu_ready (bus.lsu_wb_ready),
        .rf_rd     (bus.rf_rd),
        .rf_data   (bus.rf_data)
    );
endmodule

// File: tb/tb_id_wb_scoreboard.sv
// tb_id_wb_scoreboard: directed self-checking bench for id_wb_scoreboard
module tb_id_wb_scoreboard;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   passed = 0;
    int   failed = 0;

    id_wb_scoreboard_if bus ();

    id_wb_scoreboard dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.iss_valid    = 1'b0;
        bus.iss_rs1      = '0;
        bus.iss_rs2      = '0;
        bus.iss_rd       = '0;
        bus.iss_rd_en    = 1'b0;
        bus.alu_wb_valid = 1'b0;
        bus.alu_wb_rd    = '0;
        bus.alu_wb_data  = '0;
        bus.lsu_wb_valid = 1'b0;
        bus.lsu_wb_rd    = '0;
        bus.lsu_wb_data  = '0;
    endtask

    task automatic iss(input logic v, input int rs1, input int rs2, input int rd, input logic en);
        bus.iss_valid = v;
        bus.iss_rs1   = 5'(rs1);
        bus.iss_rs2   = 5'(rs2);
        bus.iss_rd    = 5'(rd);
        bus.iss_rd_en = en;
    endtask

    task automatic alu(input logic v, input int rd, input logic [31:0] d);
        bus.alu_wb_valid = v;
        bus.alu_wb_rd    = 5'(rd);
        bus.alu_wb_data  = d;
    endtask

    task automatic lsu(input logic v, input int rd, input logic [31:0] d);
        bus.lsu_wb_valid = v;
        bus.lsu_wb_rd    = 5'(rd);
        bus.lsu_wb_data  = d;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick();
        tick();
        chk("rst_stall", 32'(bus.iss_stall), 1);
        chk("rst_alu_rdy", 32'(bus.alu_wb_ready), 0);
        chk("rst_lsu_rdy", 32'(bus.lsu_wb_ready), 0);
        chk("rst_rf_rd", 32'(bus.rf_rd), 0);
        chk("rst_rf_data", bus.rf_data, 0);
        rst = 1'b0;
        #1;
        chk("idle_stall", 32'(bus.iss_stall), 0);
        chk("idle_alu_rdy", 32'(bus.alu_wb_ready), 1);
        chk("idle_lsu_rdy", 32'(bus.lsu_wb_ready), 1);

        // RAW on x5, resolved by an ALU write
        iss(1, 1, 2, 5, 1);
        #1 chk("iss5_stall", 32'(bus.iss_stall), 0);
        tick();
        iss(1, 5, 0, 6, 1);
        alu(1, 5, 32'hA5);
        #1 chk("raw5_stall", 32'(bus.iss_stall), 1);
        tick();
        alu(0, 0, 0);
        #1;
        chk("wb5_rf_rd", 32'(bus.rf_rd), 5);
        chk("wb5_rf_data", bus.rf_data, 32'hA5);
        chk("wb5_still_stall", 32'(bus.iss_stall), 1);
        tick();
        chk("raw5_released", 32'(bus.iss_stall), 0);
        chk("no_write_rd", 32'(bus.rf_rd), 0);
        chk("no_write_hold", bus.rf_data, 32'hA5);
        iss(0, 0, 0, 0, 0);

        // Simultaneous ALU and LSU: ALU first, LSU via buffer
        alu(1, 3, 32'h11);
        lsu(1, 4, 32'h22);
        #1;
        chk("both_alu_rdy", 32'(bus.alu_wb_ready), 1);
        chk("both_lsu_rdy", 32'(bus.lsu_wb_ready), 1);
        tick();
        idle();
        #1;
        chk("both_rf_rd3", 32'(bus.rf_rd), 3);
        chk("both_rf_data3", bus.rf_data, 32'h11);
        chk("drain_lsu_rdy", 32'(bus.lsu_wb_ready), 1);
        tick();
        chk("both_rf_rd4", 32'(bus.rf_rd), 4);
        chk("both_rf_data4", bus.rf_data, 32'h22);
        tick();
        chk("both_idle_rd", 32'(bus.rf_rd), 0);

        // Buffer starved by continuous ALU traffic drains at age 3
        alu(1, 10, 32'h100);
        lsu(1, 11, 32'h200);
        tick();
        alu(1, 12, 32'h12);
        lsu(1, 13, 32'h300);
        #1;
        chk("age0_lsu_rdy", 32'(bus.lsu_wb_ready), 0);
        chk("age0_alu_rdy", 32'(bus.alu_wb_ready), 1);
        chk("age0_rf_rd", 32'(bus.rf_rd), 10);
        tick();
        chk("age1_rf_rd", 32'(bus.rf_rd), 12);
        chk("age1_lsu_rdy", 32'(bus.lsu_wb_ready), 0);
        tick();
        chk("age2_lsu_rdy", 32'(bus.lsu_wb_ready), 0);
        chk("age2_alu_rdy", 32'(bus.alu_wb_ready), 1);
        tick();
        chk("age3_alu_rdy", 32'(bus.alu_wb_ready), 0);
        chk("age3_lsu_rdy", 32'(bus.lsu_wb_ready), 1);
        chk("age3_rf_rd", 32'(bus.rf_rd), 12);
        tick();
        idle();
        #1;
        chk("aged_rf_rd", 32'(bus.rf_rd), 11);
        chk("aged_rf_data", bus.rf_data, 32'h200);
        tick();
        chk("rebuf_rf_rd", 32'(bus.rf_rd), 13);
        chk("rebuf_rf_data", bus.rf_data, 32'h300);
        tick();
        chk("rebuf_idle_rd", 32'(bus.rf_rd), 0);

        // rd=0 writebacks are accepted and dropped; busy x20 untouched
        iss(1, 0, 0, 20, 1);
        #1 chk("iss20_stall", 32'(bus.iss_stall), 0);
        tick();
        iss(0, 0, 0, 0, 0);
        alu(1, 0, 32'hFFFF_FFFF);
        lsu(1, 0, 32'hFFFF_FFFF);
        #1;
        chk("x0_alu_rdy", 32'(bus.alu_wb_ready), 1);
        chk("x0_lsu_rdy", 32'(bus.lsu_wb_ready), 1);
        tick();
        idle();
        #1;
        chk("x0_rf_rd", 32'(bus.rf_rd), 0);
        chk("x0_rf_data", bus.rf_data, 32'h300);
        iss(1, 20, 0, 0, 0);
        #1 chk("x0_busy20", 32'(bus.iss_stall), 1);
        iss(0, 0, 0, 0, 0);
        tick();
        chk("x0_late_rd", 32'(bus.rf_rd), 0);
        chk("x0_late_data", bus.rf_data, 32'h300);

        // rd_en=0 leaves x7 free; WAW on busy x7 stalls
        iss(1, 0, 0, 7, 0);
        #1 chk("nord7_stall", 32'(bus.iss_stall), 0);
        tick();
        iss(1, 0, 0, 7, 1);
        #1 chk("rd7_free", 32'(bus.iss_stall), 0);
        tick();
        #1 chk("waw7_stall", 32'(bus.iss_stall), 1);
        iss(1, 0, 0, 7, 0);
        #1 chk("waw7_no_en", 32'(bus.iss_stall), 0);
        iss(0, 0, 0, 0, 0);

        // Reset with a full buffer and busy x9 discards everything
        iss(1, 0, 0, 9, 1);
        #1 chk("iss9_stall", 32'(bus.iss_stall), 0);
        tick();
        iss(0, 0, 0, 0, 0);
        alu(1, 14, 32'h14);
        lsu(1, 9, 32'h99);
        tick();
        lsu(0, 0, 0);
        #1 chk("full_lsu_rdy", 32'(bus.lsu_wb_ready), 0);
        rst = 1'b1;
        idle();
        #1;
        chk("midrst_stall", 32'(bus.iss_stall), 1);
        chk("midrst_alu_rdy", 32'(bus.alu_wb_ready), 0);
        chk("midrst_lsu_rdy", 32'(bus.lsu_wb_ready), 0);
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_rd", 32'(bus.rf_rd), 0);
        chk("post_rst_data", bus.rf_data, 0);
        iss(1, 9, 7, 20, 1);
        #1 chk("post_rst_busy", 32'(bus.iss_stall), 0);
        iss(0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_rst_nowrite", 32'(bus.rf_rd), 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
